// File: rtl/mux41_rr_arbiter_if.sv
// Requester-side bus of the shared 4:1 mux arbiter: request/data in, grant/select/sample out.
interface mux41_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] a;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       y;
   logic       y_valid;
   logic       busy;

   modport master (output req, a, input sel, gnt, y, y_valid, busy);
   modport slave  (input req, a, output sel, gnt, y, y_valid, busy);
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 one-bit mux between four requesters, with bounded hold.
// Optional MUX41_ARB_PARK_EN: keep the last grant parked while idle so its owner resumes with no latency.
module mux41_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 4
) (
   input logic              clk,
   input logic              rst_n,
   mux41_rr_arbiter_if.slave bus
);
   localparam int unsigned N     = 4;
   localparam int unsigned SEL_W = 2;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_PARK  = 2'd2
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] ptr;
   logic [N-1:0]     gnt_q;
   logic [CNT_W-1:0] hold_cnt;
   logic             y_q;
   logic             y_valid_q;
   logic             busy_q;

   logic [N-1:0]     others_c;
   logic [SEL_W-1:0] win_ptr_c;
   logic [SEL_W-1:0] win_next_c;

   // First set request scanning from start upward, modulo 4.
   function automatic logic [SEL_W-1:0] pick(input logic [N-1:0] r, input logic [SEL_W-1:0] start);
      logic [SEL_W-1:0] idx;
      logic             found;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = start + SEL_W'(i);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   endfunction

   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
      onehot = N'(1) << i;
   endfunction

   assign others_c   = bus.req & ~onehot(sel_q);
   assign win_ptr_c  = pick(bus.req, ptr);
   assign win_next_c = pick(bus.req, sel_q + SEL_W'(1));

   // Sample path follows busy: with parking, a parked grant must not produce valid samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         ptr       <= '0;
         hold_cnt  <= '0;
         y_q       <= 1'b0;
         y_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         y_q       <= busy_q ? bus.a[sel_q] : 1'b0;
         y_valid_q <= busy_q;
         case (state)
            S_IDLE: begin
               if (|bus.req) begin
                  gnt_q    <= onehot(win_ptr_c);
                  sel_q    <= win_ptr_c;
                  hold_cnt <= CNT_W'(1);
                  busy_q   <= 1'b1;
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!bus.req[sel_q]) begin
                  ptr <= sel_q + SEL_W'(1);
                  if (|others_c) begin
                     gnt_q    <= onehot(win_next_c);
                     sel_q    <= win_next_c;
                     hold_cnt <= CNT_W'(1);
                  end else begin
                     busy_q <= 1'b0;
`ifdef MUX41_ARB_PARK_EN
                     state  <= S_PARK;
`else
                     gnt_q  <= '0;
                     state  <= S_IDLE;
`endif
                  end
               end else if ((hold_cnt == HOLD_LIM) && (|others_c)) begin
                  // Hold budget spent with others waiting: rotate past the current owner.
                  ptr      <= sel_q + SEL_W'(1);
                  gnt_q    <= onehot(win_next_c);
                  sel_q    <= win_next_c;
                  hold_cnt <= CNT_W'(1);
               end else if (hold_cnt != HOLD_LIM) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
`ifdef MUX41_ARB_PARK_EN
            S_PARK: begin
               if (bus.req[sel_q]) begin
                  hold_cnt <= CNT_W'(1);
                  busy_q   <= 1'b1;
                  state    <= S_GRANT;
               end else if (|bus.req) begin
                  gnt_q    <= onehot(win_ptr_c);
                  sel_q    <= win_ptr_c;
                  hold_cnt <= CNT_W'(1);
                  busy_q   <= 1'b1;
                  state    <= S_GRANT;
               end
            end
`endif
            default: begin
               gnt_q  <= '0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed, table-driven bench for mux41_rr_arbiter (HOLD_MAX=4); expectations follow MUX41_ARB_PARK_EN.
module tb_mux41_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   mux41_rr_arbiter_if bus ();

   mux41_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] a;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       y;
      logic       yv;
      logic       busy;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] av,
                               input logic [3:0] g, input logic [1:0] s, input logic yy,
                               input logic v, input logic b);
      vec_t t;
      t.rst_n = r; t.req = rq; t.a = av; t.gnt = g; t.sel = s; t.y = yy; t.yv = v; t.busy = b;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input int idx, input logic [3:0] g, input logic [1:0] s,
                          input logic yy, input logic v, input logic b);
      chk({nm, "_gnt"},  idx, 8'(bus.gnt),     8'(g));
      chk({nm, "_sel"},  idx, 8'(bus.sel),     8'(s));
      chk({nm, "_y"},    idx, 8'(bus.y),       8'(yy));
      chk({nm, "_yv"},   idx, 8'(bus.y_valid), 8'(v));
      chk({nm, "_busy"}, idx, 8'(bus.busy),    8'(b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      bus.a   = 4'b0000;

      //           rst  req      a        gnt      sel   y     yv    busy
      vt[0]  = mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      vt[1]  = mk(1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      vt[2]  = mk(1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1);
      vt[3]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      vt[4]  = mk(1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1);
      vt[5]  = mk(1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);
      vt[6]  = mk(1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
      vt[7]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);
      vt[8]  = mk(1'b1, 4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
      vt[9]  = mk(1'b1, 4'b1000, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
      vt[10] = mk(1'b1, 4'b1000, 4'b0010, 4'b1000, 2'd3, 1'b0, 1'b1, 1'b1);
      vt[11] = mk(1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
      vt[12] = mk(1'b1, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1);
      vt[13] = mk(1'b1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b1);
      vt[14] = mk(1'b1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
      vt[15] = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
      vt[16] = mk(1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
`ifdef MUX41_ARB_PARK_EN
      // Parked grant stays on the last owner; owner 0 resumes directly at vector 16.
      vt[6].gnt  = 4'b0100;
      vt[7].gnt  = 4'b0100;
      vt[15].gnt = 4'b0001;
      vt[16].gnt = 4'b0001;
      vt[16].sel = 2'd0;
`endif

      for (int i = 0; i < 17; i++) begin
         rst_n   = vt[i].rst_n;
         bus.req = vt[i].req;
         bus.a   = vt[i].a;
         step();
         chk_all("vec", i, vt[i].gnt, vt[i].sel, vt[i].y, vt[i].yv, vt[i].busy);
      end

      // Fairness: all four requesting from reset rotate every HOLD_MAX cycles.
      rst_n   = 1'b0;
      bus.req = 4'b1111;
      bus.a   = 4'b0000;
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         logic [3:0] exp_g;
         exp_g = 4'b0001 << ((k / 4) % 4);
         step();
         chk("fair_gnt", k, 8'(bus.gnt), 8'(exp_g));
         chk("fair_onehot", k, 8'($onehot(bus.gnt)), 8'd1);
      end

      // Reset mid-grant must also clear the rotation pointer.
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      step();
      rst_n   = 1'b1;
      bus.req = 4'b0010;
      step();
      bus.req = 4'b0000;
      step();
      bus.req = 4'b0100;
      step();
      step();
      step();
      chk_all("midrst_pre", 0, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1);
      rst_n = 1'b0;
      step();
      chk_all("midrst_rst", 0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      rst_n   = 1'b1;
      bus.req = 4'b0101;
      step();
      chk("midrst_gnt", 0, 8'(bus.gnt), 8'h01);
      chk("midrst_sel", 0, 8'(bus.sel), 8'h00);

      // Release and re-request of the same owner (parked or idle).
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      step();
      rst_n   = 1'b1;
      bus.req = 4'b0010;
      bus.a   = 4'b0010;
      step();
      chk_all("park_grant", 0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
      step();
      chk_all("park_grant", 1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);
      bus.req = 4'b0000;
      step();
`ifdef MUX41_ARB_PARK_EN
      chk_all("park_drop", 0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("park_drop", 1, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0);
`else
      chk_all("park_drop", 0, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0);
      step();
      chk_all("park_drop", 1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
`endif
      bus.req = 4'b0010;
      step();
      chk_all("park_resume", 0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
      step();
      chk_all("park_resume", 1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 one-bit mux between four requesters.
- Each requester raises req[i] and presents its data bit on a[i]; the arbiter grants one requester and drives the mux select.
- The selected bit is registered out on y.
- Sits in front of the mux41 datapath as its sequencing/sharing controller; bounded hold time prevents starvation.

Parameters:
- HOLD_MAX, 4, maximum consecutive grant cycles while others wait; legal 1..15.
- CNT_W, 4, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  4  request per requester, level-sensitive
- a  input  4  data bit per requester, mux inputs
- sel  output  2  registered mux select, index of current/last grantee
- gnt  output  4  registered one-hot grant; all zero when idle
- y  output  1  registered mux output, a[sel] sampled one cycle earlier
- y_valid  output  1  y holds a granted sample
- busy  output  1  high in GRANT state

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, gnt=0, sel=0, y=0, y_valid=0, busy=0, ptr=0, hold_cnt=0. Applies mid-operation; overrides all other events that edge.
- ptr = highest-priority index. Winner = first set req bit scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If req==0: stay IDLE.
  - Else: next edge load gnt=onehot(winner), sel=winner, hold_cnt=1, state=GRANT.
  - Latency req->gnt: 1 cycle.
- GRANT, evaluated each edge with current sel=s:
  - (a) req[s]=0, other reqs pending: ptr=s+1, grant winner from ptr directly; no idle bubble; hold_cnt=1.
  - (b) req[s]=0, none pending: gnt=0, state=IDLE, ptr=s+1, sel holds s.
  - (c) req[s]=1, hold_cnt==HOLD_MAX, others pending: ptr=s+1, grant winner from ptr, hold_cnt=1.
  - (d) req[s]=1, otherwise: keep grant; hold_cnt increments, saturating at HOLD_MAX.
- y/y_valid:
  - Every edge, y <= a[sel] if gnt!=0, else y <= 0.
  - y_valid <= (gnt!=0).
  - So y_valid trails gnt by exactly one cycle.
- busy = (state==GRANT), registered with gnt.
- gnt is always one-hot or zero. sel changes only when a new grant is loaded.
- HOLD_MAX=1: strict per-cycle rotation whenever more than one requester is pending.

Optional Feature:
- Macro MUX41_ARB_PARK_EN.
- Defined:
  - Case (b) enters PARK instead of IDLE: gnt stays onehot(s), busy=0, y_valid=0, y=0.
  - In PARK, req[s] re-asserting returns to GRANT with zero added latency (gnt already set), hold_cnt=1.
  - In PARK, any other request is arbitrated from ptr as in IDLE, 1-cycle switch.
  - Reset still clears gnt to 0.
- Undefined: no PARK state; behaviour exactly as above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=1111 -> gnt=0000, sel=0, y=0, y_valid=0, busy=0 throughout; rst_n=1 -> gnt=0001 one cycle later.
- Single requester: req=0100, a=0100 -> next cycle gnt=0100, sel=2, busy=1; following cycle y=1, y_valid=1; drop req -> gnt=0000 next cycle, y_valid=0 one cycle after.
- Fairness: req=1111 constant from reset, HOLD_MAX=4 -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, 0001; never two bits set.
- Back-to-back release: gnt=0010, req goes 0010->1000 same edge -> gnt=1000 next cycle, no zero cycle; y tracks a[3] one cycle later.
- Reset mid-grant: gnt=0100, hold_cnt=3, pulse rst_n=0 one cycle -> all outputs reset values; then req=0101 -> gnt=0001 (ptr reset to 0).
- PARK (macro on): grant 0010, drop all req -> gnt stays 0010, busy=0, y_valid=0; reassert req[1] -> busy=1 same-latency, y_valid=1 next cycle; with macro off, gnt=0000 instead.
